// File: rtl/risc_mc_pkg.sv
`default_nettype none
// risc_mc_pkg -- opcodes, instruction field positions and FSM states for risc_mc_core (rev 1.0)
package risc_mc_pkg;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_INV  = 4'h4;
  localparam logic [3:0] OP_LSL  = 4'h5;
  localparam logic [3:0] OP_LSR  = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_OR   = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int RS1_HI = 11;
  localparam int RS1_LO = 9;
  localparam int RS2_HI = 8;
  localparam int RS2_LO = 6;
  localparam int RD_HI  = 5;
  localparam int RD_LO  = 3;
  localparam int OFF_HI = 5;
  localparam int TGT_HI = 11;

  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/risc_mc_regfile.sv
`default_nettype none
// risc_mc_regfile -- 8 x DATA_W register file, two async reads, one sync write (rev 1.0)
module risc_mc_regfile
  import risc_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '0;
    else        regs_q <= regs_d;
  end

  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];

endmodule
`default_nettype wire

// File: rtl/risc_mc_core.sv
`default_nettype none
// risc_mc_core -- multi-cycle RISC core with req/ack instruction and data ports (rev 1.0)
module risc_mc_core
  import risc_mc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 16,
  parameter int NUM_CHAINS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CHAINS-1:0] test_si,
  input  logic                  test_se,
  output logic [NUM_CHAINS-1:0] test_so,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic [15:0]           imem_rdata,
  input  logic                  imem_ack,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [PC_W-1:0]       dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic [DATA_W-1:0]     dmem_rdata,
  input  logic                  dmem_ack,
  output logic                  halted
);

  localparam logic [DATA_W-1:0] DW_MOD = DATA_W'(DATA_W);

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic                imem_req_q, imem_req_d;
  logic [PC_W-1:0]     imem_addr_q, imem_addr_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [PC_W-1:0]     dmem_addr_q, dmem_addr_d;
  logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic                halted_q, halted_d;

  logic [3:0]          opcode;
  logic [REG_AW-1:0]   rs1, rs2, rd;
  logic [5:0]          off6;
  logic [11:0]         target;
  logic [DATA_W-1:0]   off_ext, ea, shamt, alu_res;
  logic [PC_W-1:0]     off_pc, jmp_pc;
  logic [DATA_W-1:0]   rf_rdata1, rf_rdata2;
  logic                rf_we;
  logic [REG_AW-1:0]   rf_waddr;
  logic                unused_ok;

  assign opcode  = ir_q[OPC_HI:OPC_LO];
  assign rs1     = ir_q[RS1_HI:RS1_LO];
  assign rs2     = ir_q[RS2_HI:RS2_LO];
  assign rd      = ir_q[RD_HI:RD_LO];
  assign off6    = ir_q[OFF_HI:0];
  assign target  = ir_q[TGT_HI:0];
  assign off_ext = {{(DATA_W-6){off6[5]}}, off6};
  assign off_pc  = {{(PC_W-6){off6[5]}}, off6};
  assign ea      = a_q + off_ext;
  assign shamt   = b_q % DW_MOD;

  generate
    if (PC_W > 12) begin : g_jmp_wide
      assign jmp_pc = {pc_q[PC_W-1:12], target};
    end else begin : g_jmp_narrow
      assign jmp_pc = target[PC_W-1:0];
    end
  endgenerate

  risc_mc_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (rf_we),
    .waddr  (rf_waddr),
    .wdata  (res_q),
    .raddr1 (rs1),
    .rdata1 (rf_rdata1),
    .raddr2 (rs2),
    .rdata2 (rf_rdata2)
  );

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_INV:  alu_res = ~a_q;
      OP_LSL:  alu_res = a_q << shamt;
      OP_LSR:  alu_res = a_q >> shamt;
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    halted_d     = halted_q;
    rf_we        = 1'b0;
    rf_waddr     = rd;

    case (state_q)
      S_FETCH: begin
        if (imem_req_q && imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_rdata1;
        b_d     = rf_rdata2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode)
          OP_LD, OP_ST: begin
            dmem_addr_d  = ea[PC_W-1:0];
            dmem_we_d    = (opcode == OP_ST);
            dmem_wdata_d = b_q;
            state_d      = S_MEM;
          end
          OP_ADD, OP_SUB, OP_INV, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_SLT: begin
            res_d   = alu_res;
            state_d = S_WB;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + off_pc;
            state_d = S_FETCH;
          end
          OP_BNE: begin
            if (a_q != b_q) pc_d = pc_q + off_pc;
            state_d = S_FETCH;
          end
          OP_JMP: begin
            pc_d    = jmp_pc;
            state_d = S_FETCH;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (dmem_req_q && dmem_ack) begin
          dmem_we_d = 1'b0;
          if (dmem_we_q) begin
            state_d = S_FETCH;
          end else begin
            res_d   = dmem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = (opcode == OP_LD) ? rs2 : rd;
        state_d  = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Requests are registered: raise them on the edge that enters the state.
    imem_req_d  = (state_d == S_FETCH);
    imem_addr_d = (state_d == S_FETCH) ? pc_d : imem_addr_q;
    dmem_req_d  = (state_d == S_MEM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      halted_q     <= halted_d;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign halted     = halted_q;
  assign test_so    = '0;

  // Scan ports are stitched by the DFT flow; upper effective-address bits are discarded.
  assign unused_ok = &{1'b0, test_si, test_se, ea};

endmodule
`default_nettype wire

// File: tb/tb_risc_mc_core.sv
`default_nettype none
// tb_risc_mc_core -- vector table plus scoreboarded data-port checks for risc_mc_core (rev 1.0)
module tb_risc_mc_core;
  import risc_mc_pkg::*;

  localparam int DATA_W = 32;
  localparam int PC_W   = 16;
  localparam int NCH    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    test_si = '0;
  logic              test_se = 1'b0;
  logic [NCH-1:0]    test_so;
  logic              imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, halted;
  logic [PC_W-1:0]   imem_addr, dmem_addr;
  logic [15:0]       imem_rdata;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata;

  logic [15:0] imem [0:255];
  logic [31:0] dmem [0:255];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, cyc = 0;
  logic dack_force = 1'b0;

  typedef struct { logic we; logic [15:0] addr; logic [31:0] data; } acc_t;
  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;

  acc_t sb[$];
  acc_t mon_e;
  int   fetch_addr[$];
  int   fetch_cyc[$];
  vec_t vt[14];
  int   n_vec = 0, n_err = 0;
  string tag = "init";

  logic            ip_req = 0, ip_ack = 0, dp_req = 0, dp_ack = 0, dp_we = 0;
  logic [PC_W-1:0] ip_addr = '0, dp_addr = '0;
  logic [31:0]     dp_wdata = '0;

  risc_mc_core #(.DATA_W(DATA_W), .PC_W(PC_W), .NUM_CHAINS(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .test_si(test_si), .test_se(test_se), .test_so(test_so),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .halted(halted)
  );

  always #5 clk = ~clk;

  assign imem_ack   = imem_req && (icnt >= iwait);
  assign imem_rdata = imem[imem_addr[7:0]];
  assign dmem_ack   = (dmem_req && (dcnt >= dwait)) || dack_force;
  assign dmem_rdata = dmem[dmem_addr[7:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h, expected %0h", tag, nm, act, exp);
    end
  endtask

  // Port monitor: hold rules while stalled, fetch log, data-port scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      ip_req = 0; dp_req = 0; ip_ack = 0; dp_ack = 0;
    end else begin
      if (imem_req && ip_req && !ip_ack) chk("imem_addr_hold", imem_addr, ip_addr);
      if (dmem_req && dp_req && !dp_ack) begin
        chk("dmem_addr_hold", dmem_addr, dp_addr);
        chk("dmem_we_hold", dmem_we, dp_we);
        chk("dmem_wdata_hold", dmem_wdata, dp_wdata);
      end
      if (imem_req && imem_ack) begin
        fetch_addr.push_back(int'(imem_addr));
        fetch_cyc.push_back(cyc);
      end
      if (dmem_req && dmem_ack) begin
        if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL %s/sb_unexpected: access at %0h, expected none", tag, dmem_addr);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_we", dmem_we, mon_e.we);
          chk("sb_addr", dmem_addr, mon_e.addr);
          if (mon_e.we) chk("sb_wdata", dmem_wdata, mon_e.data);
        end
      end
      ip_req = imem_req; ip_ack = imem_ack; ip_addr = imem_addr;
      dp_req = dmem_req; dp_ack = dmem_ack; dp_addr = dmem_addr;
      dp_we = dmem_we; dp_wdata = dmem_wdata;
    end
  end

  function automatic logic [15:0] enc_r(input logic [3:0] op, input int s1, input int s2, input int d);
    return {op, 3'(s1), 3'(s2), 3'(d), 3'b000};
  endfunction
  function automatic logic [15:0] enc_i(input logic [3:0] op, input int s1, input int s2, input int off);
    return {op, 3'(s1), 3'(s2), 6'(off)};
  endfunction
  function automatic logic [15:0] enc_j(input int t);
    return {OP_JMP, 12'(t)};
  endfunction

  task automatic push(input logic we, input logic [15:0] addr, input logic [31:0] data);
    acc_t e;
    e.we = we; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i] = {OP_HALT, 12'h000};
      dmem[i] = '0;
    end
  endtask

  task automatic load_alu(input vec_t v);
    clear_mem();
    imem[0] = enc_i(OP_LD, 0, 1, 0);
    imem[1] = enc_i(OP_LD, 0, 2, 1);
    imem[2] = enc_r(v.op, 1, 2, 3);
    imem[3] = enc_i(OP_ST, 0, 3, 2);
    dmem[0] = v.a;
    dmem[1] = v.b;
    push(1'b0, 16'd0, v.a);
    push(1'b0, 16'd1, v.b);
    push(1'b1, 16'd2, v.exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    fetch_addr.delete();
    fetch_cyc.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", halted, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic chk_fetch(input int exp_addr[]);
    chk("fetch_count", fetch_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < fetch_addr.size(); i++)
      chk($sformatf("fetch_addr%0d", i), fetch_addr[i], exp_addr[i]);
  endtask

  task automatic chk_cpi(input int idx, input int exp);
    if (idx + 1 < fetch_cyc.size()) chk($sformatf("cpi%0d", idx), fetch_cyc[idx+1] - fetch_cyc[idx], exp);
    else chk($sformatf("cpi%0d_missing", idx), fetch_cyc.size(), idx + 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{OP_ADD, 32'd5,         32'd7,         32'd12};
    vt[1]  = '{OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0};
    vt[2]  = '{OP_SUB, 32'd0,         32'd1,         32'hFFFF_FFFF};
    vt[3]  = '{OP_SUB, 32'd10,        32'd3,         32'd7};
    vt[4]  = '{OP_INV, 32'h0F0F_0F0F, 32'd0,         32'hF0F0_F0F0};
    vt[5]  = '{OP_LSL, 32'd1,         32'd33,        32'd2};
    vt[6]  = '{OP_LSL, 32'd1,         32'd31,        32'h8000_0000};
    vt[7]  = '{OP_LSR, 32'h8000_0000, 32'd4,         32'h0800_0000};
    vt[8]  = '{OP_LSR, 32'h0000_1234, 32'd32,        32'h0000_1234};
    vt[9]  = '{OP_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000};
    vt[10] = '{OP_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F};
    vt[11] = '{OP_SLT, 32'hFFFF_FFFF, 32'd1,         32'd1};
    vt[12] = '{OP_SLT, 32'd1,         32'hFFFF_FFFF, 32'd0};
    vt[13] = '{OP_SLT, 32'd5,         32'd5,         32'd0};

    // Reset values and first request timing.
    tag = "reset";
    load_alu(vt[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("imem_req", imem_req, 0);
    chk("imem_addr", imem_addr, 0);
    chk("dmem_req", dmem_req, 0);
    chk("dmem_we", dmem_we, 0);
    chk("dmem_addr", dmem_addr, 0);
    chk("dmem_wdata", dmem_wdata, 0);
    chk("halted", halted, 0);
    chk("test_so", test_so, 0);
    rst_n = 1'b1;
    chk("req_before_edge", imem_req, 0);
    @(posedge clk);
    #1;
    chk("req_cycle1", imem_req, 1);
    chk("addr_cycle1", imem_addr, 0);
    wait_halt(300);
    chk_fetch('{0, 1, 2, 3, 4});
    chk_cpi(0, 5);
    chk_cpi(1, 5);
    chk_cpi(2, 4);
    chk_cpi(3, 4);

    for (int i = 0; i < 14; i++) begin
      tag = $sformatf("vec%0d", i);
      load_alu(vt[i]);
      do_reset();
      wait_halt(300);
      chk("fetch_count", fetch_addr.size(), 5);
    end

    // Wait states: 3 on fetch, 2 on data.
    tag = "waits";
    iwait = 3; dwait = 2;
    load_alu(vt[0]);
    do_reset();
    wait_halt(600);
    chk_fetch('{0, 1, 2, 3, 4});
    chk_cpi(0, 10);
    chk_cpi(1, 10);
    chk_cpi(2, 7);
    chk_cpi(3, 9);
    iwait = 0; dwait = 0;

    // Store then load the same word, plus a negative offset store.
    tag = "st_ld";
    clear_mem();
    dmem[0] = 32'h0000_BEEF;
    imem[0] = enc_i(OP_LD, 0, 1, 0);
    imem[1] = enc_i(OP_ST, 0, 1, 16);
    imem[2] = enc_i(OP_LD, 0, 2, 16);
    imem[3] = enc_i(OP_ST, 0, 2, 17);
    imem[4] = enc_i(OP_ST, 1, 1, -1);
    push(1'b0, 16'd0, 32'h0);
    push(1'b1, 16'd16, 32'h0000_BEEF);
    push(1'b0, 16'd16, 32'h0);
    push(1'b1, 16'd17, 32'h0000_BEEF);
    push(1'b1, 16'hBEEE, 32'h0000_BEEF);
    do_reset();
    wait_halt(300);
    chk("mem17", dmem[17], 32'h0000_BEEF);
    chk("memEE", dmem[8'hEE], 32'h0000_BEEF);
    chk_cpi(1, 4);

    // Branches taken and not taken, JMP.
    tag = "branch";
    clear_mem();
    dmem[0]  = 32'd5;
    imem[0]  = enc_i(OP_LD, 0, 1, 0);
    imem[1]  = enc_i(OP_BNE, 1, 0, 2);
    imem[4]  = enc_i(OP_BEQ, 1, 1, -2);
    imem[3]  = enc_j(8);
    imem[8]  = enc_i(OP_BEQ, 1, 0, -2);
    imem[9]  = enc_i(OP_BNE, 1, 1, -2);
    push(1'b0, 16'd0, 32'h0);
    do_reset();
    wait_halt(300);
    chk_fetch('{0, 1, 4, 3, 8, 9, 10});
    chk_cpi(1, 3);
    chk_cpi(2, 3);
    chk_cpi(3, 3);

    tag = "bne_nop";
    clear_mem();
    imem[0] = enc_j(4);
    imem[4] = enc_i(OP_BNE, 0, 0, -2);
    imem[5] = 16'hE000;
    imem[6] = 16'hA000;
    do_reset();
    wait_halt(300);
    chk_fetch('{0, 4, 5, 6, 7});
    chk_cpi(2, 3);

    tag = "halt_quiet";
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("no_reqs", {imem_req, dmem_req, halted}, 3'b001);
    end

    // Reset pulse during a stalled load, then a spurious ack right after reset.
    tag = "reset_mid_mem";
    clear_mem();
    dwait = 20;
    imem[0] = enc_i(OP_LD, 0, 1, 5);
    push(1'b0, 16'd5, 32'h0);
    do_reset();
    begin
      int n = 0;
      while (!dmem_req && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    chk("mem_reached", dmem_req, 1);
    repeat (2) @(negedge clk);
    chk("mem_addr_pre", dmem_addr, 5);
    rst_n = 1'b0;
    #1;
    chk("async_dmem_req", dmem_req, 0);
    chk("async_dmem_addr", dmem_addr, 0);
    chk("async_imem_req", imem_req, 0);
    chk("async_halted", halted, 0);
    sb.delete();
    dwait = 0;
    load_alu(vt[3]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    fetch_addr.delete();
    fetch_cyc.delete();
    rst_n = 1'b1;
    dack_force = 1'b1;
    @(negedge clk);
    dack_force = 1'b0;
    wait_halt(300);
    chk_fetch('{0, 1, 2, 3, 4});
    chk("mem2", dmem[2], 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_mc_core.md
# risc_mc_core

Parametrised multi-cycle successor to the 16-bit single-cycle RISC top: same instruction format and opcodes, configurable data width and scan-chain count, plus HALT. Fetches and accesses data through external req/ack memory ports, so wait-state memories replace the built-in program/data arrays. It is the processor top of the DFT test vehicle; scan stitching is added by the DFT flow.

## Interface
Parameters:
- DATA_W, 16, register/ALU/data-bus width (≥16)
- PC_W, 16, word-address width for instruction and data ports
- NUM_CHAINS, 4, number of scan chains (test_si/test_so width)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- test_si  in  NUM_CHAINS  scan inputs (RTL: unused)
- test_se  in  1  scan enable (RTL: functionally ignored)
- test_so  out  NUM_CHAINS  scan outputs (RTL: tied 0, replaced at insertion)
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch word address
- imem_rdata  in  16  instruction
- imem_ack  in  1  fetch complete, imem_rdata valid this cycle
- dmem_req  out  1  data request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  PC_W  data word address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data
- dmem_ack  in  1  data access complete, dmem_rdata valid this cycle
- halted  out  1  core has executed HALT

## Operation
- Format: [15:12] opcode, [11:9] rs1, [8:6] rs2, [5:3] rd (R-type), [5:0] off6 (I-type), [11:0] target (JMP).
- Opcodes: 0 LD rs2←M[rs1+sext(off6)]; 1 ST M[rs1+sext(off6)]←rs2; 2 ADD; 3 SUB; 4 INV (rd←~rs1); 5 LSL; 6 LSR (shift rs1 by rs2 mod DATA_W); 7 AND; 8 OR; 9 SLT (signed, rd←1/0); B BEQ; C BNE (pc←pc+1+sext(off6) when taken); D JMP pc←{pc[PC_W-1:12],target}; F HALT; A, E NOP.
- Arithmetic wraps modulo 2^DATA_W; addresses are the low PC_W bits of the computed sum.
- Register file: 8 × DATA_W, all writable, reset to 0; 2 async reads, 1 sync write.
- FSM: FETCH → DECODE → EXEC → {MEM → WB | WB | FETCH} ; HALT state terminal.
  - FETCH: imem_req=1, imem_addr=pc; on imem_ack latch IR, pc←pc+1 → DECODE.
  - DECODE: read operands → EXEC.
  - EXEC: ALU/branch compare; LD/ST → MEM; ALU ops → WB; branches/JMP/NOP → FETCH (pc updated); HALT → HALT.
  - MEM: dmem_req=1 with addr/we/wdata stable until dmem_ack; LD latches rdata → WB; ST → FETCH.
  - WB: write rd (ALU) or rs2 (LD) → FETCH.
- HALT: halted=1, no further requests until reset.

## Timing
- Reset values: pc=0, state=FETCH, all req/we=0, addr/wdata=0, halted=0, test_so=0.
- First imem_req rises in the first clk edge after rst_n deasserts (registered outputs).
- Req rule: req and address/data held constant until the cycle ack=1; req drops the following cycle. ack without req ignored.
- Zero-wait latency (cycles per instruction): ALU 4, LD 5, ST 4, branch/JMP/NOP 3; each memory wait cycle adds 1.
- Branch target uses pc already incremented in FETCH.
- Reset mid-access: all outputs clear asynchronously; a pending ack after reset is ignored.
- pc wraps from 2^PC_W−1 to 0.

## Structure
- Package risc_mc_pkg: opcode localparams, FSM state enum, field bit positions.
- Sub-module risc_mc_regfile (8×DATA_W, parametrised width); ALU inline in the core.

## Test plan
- Reset, zero-wait memory, program ADD r3=r1+r2 (r1=5,r2=7 via LD) → r3=12, imem_req high at cycle 1, ALU instruction 4 cycles.
- imem_ack delayed 3 cycles → imem_addr/req stable throughout, CPI rises by 3, no double fetch.
- ST then LD same address (M[0x10]←0xBEEF) → LD returns 0xBEEF, dmem_we 1 then 0.
- BEQ r1==r1 off6=−2 at pc=4 → next fetch address 3; BNE same operands → fetch 5.
- DATA_W=32: SUB 0−1 → 0xFFFFFFFF; SLT −1<1 → 1; LSL by 33 → shift by 1.
- HALT then rst_n pulse mid-MEM → halted=1 with no reqs; after reset halted=0, fetch from 0.
